// File: rtl/uart_fifo_ctrl_param.sv
// uart_fifo_ctrl_param: parametrised UART FIFO controller with FWFT option, threshold flag, sticky errors and flush
module uart_fifo_ctrl_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 128,
  parameter int CNT_BITS = 8,
  parameter int FWFT     = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clr,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                write_n,
  input  logic                read_n,
  input  logic [CNT_BITS-1:0] level,
  input  logic                flag_clr,
  output logic [WIDTH-1:0]    data_out,
  output logic                data_valid,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                geq_level,
  output logic                overflow,
  output logic                underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic ovf_q, ovf_d, udf_q, udf_d, dv_q, dv_d;
  logic wr_en, rd_en;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full       = count_q == CNT_BITS'(DEPTH);
  assign empty      = count_q == '0;
  assign count      = count_q;
  assign geq_level  = count_q >= level;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign rd_en      = ~read_n & ~empty;
  assign wr_en      = ~write_n & (~full | rd_en);
  assign data_out   = (FWFT != 0) ? mem[rd_ptr_q] : dout_q;
  assign data_valid = (FWFT != 0) ? ~empty : dv_q;
  // next state; flush beats traffic and errors, a new error beats flag_clr
  always_comb begin
    wr_ptr_d = clr ? '0 : wr_en ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = clr ? '0 : rd_en ? inc(rd_ptr_q) : rd_ptr_q;
    count_d  = clr ? '0 : (wr_en & ~rd_en) ? count_q + 1'b1 : (rd_en & ~wr_en) ? count_q - 1'b1 : count_q;
    ovf_d    = ~clr & ((ovf_q & ~flag_clr) | (~write_n & full & ~rd_en));
    udf_d    = ~clr & ((udf_q & ~flag_clr) | (~read_n & empty));
    dv_d     = ~clr & rd_en;
    dout_d   = clr ? '0 : rd_en ? mem[rd_ptr_q] : dout_q;
  end
  // control state with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dv_q     <= dv_d;
      dout_q   <= dout_d;
    end
  end
  // storage array, deliberately unreset so it maps to plain registers or RAM
  always_ff @(posedge clock) begin
    if (wr_en && !clr) mem[wr_ptr_q] <= data_in;
  end
endmodule

// File: tb/tb_uart_fifo_ctrl_param.sv
// tb_uart_fifo_ctrl_param: scoreboard bench over three FIFO configurations
module tb_uart_fifo_ctrl_param;
  logic clock, reset_n;
  logic [2:0] clr, wr_n, rd_n, fclr;
  logic [7:0] din [3];
  logic [7:0] lvl [3];
  logic [7:0] dout [3];
  logic [7:0] cnt [3];
  logic full [3];
  logic empty [3];
  logic geq [3];
  logic ovf [3];
  logic udf [3];
  logic dv [3];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  int total = 0, bad = 0;

  uart_fifo_ctrl_param #(.WIDTH(8), .DEPTH(128), .CNT_BITS(8), .FWFT(0)) u_a (
    .clock(clock), .reset_n(reset_n), .clr(clr[0]), .data_in(din[0]), .write_n(wr_n[0]),
    .read_n(rd_n[0]), .level(lvl[0]), .flag_clr(fclr[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .count(cnt[0]), .full(full[0]), .empty(empty[0]), .geq_level(geq[0]), .overflow(ovf[0]),
    .underflow(udf[0]));
  uart_fifo_ctrl_param #(.WIDTH(8), .DEPTH(5), .CNT_BITS(8), .FWFT(0)) u_b (
    .clock(clock), .reset_n(reset_n), .clr(clr[1]), .data_in(din[1]), .write_n(wr_n[1]),
    .read_n(rd_n[1]), .level(lvl[1]), .flag_clr(fclr[1]), .data_out(dout[1]), .data_valid(dv[1]),
    .count(cnt[1]), .full(full[1]), .empty(empty[1]), .geq_level(geq[1]), .overflow(ovf[1]),
    .underflow(udf[1]));
  uart_fifo_ctrl_param #(.WIDTH(8), .DEPTH(4), .CNT_BITS(8), .FWFT(1)) u_c (
    .clock(clock), .reset_n(reset_n), .clr(clr[2]), .data_in(din[2]), .write_n(wr_n[2]),
    .read_n(rd_n[2]), .level(lvl[2]), .flag_clr(fclr[2]), .data_out(dout[2]), .data_valid(dv[2]),
    .count(cnt[2]), .full(full[2]), .empty(empty[2]), .geq_level(geq[2]), .overflow(ovf[2]),
    .underflow(udf[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input bit have, input logic [7:0] e, input logic [7:0] a);
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s: unexpected word 0x%02h, scoreboard empty", nm, a);
    end else if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, a, e);
    end
  endtask

  always @(negedge clock) begin
    logic [7:0] e;
    bit h;
    if (reset_n) begin
      if (dv[0]) begin
        h = q0.size() != 0;
        e = h ? q0.pop_front() : 8'h00;
        cmp("a_data", h, e, dout[0]);
      end
      if (dv[1]) begin
        h = q1.size() != 0;
        e = h ? q1.pop_front() : 8'h00;
        cmp("b_data", h, e, dout[1]);
      end
      if (dv[2] && !rd_n[2]) begin
        h = q2.size() != 0;
        e = h ? q2.pop_front() : 8'h00;
        cmp("c_data", h, e, dout[2]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int nw, mc;
    bit w, r;
    reset_n = 1'b0;
    clr = '0; wr_n = '1; rd_n = '1; fclr = '0;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    lvl[0] = 8'd0; lvl[1] = 8'd3; lvl[2] = 8'd1;
    cyc(); cyc();
    chk("rst_count", cnt[0], 0);
    chk("rst_empty", empty[0], 1);
    chk("rst_full", full[0], 0);
    chk("rst_geq_lvl0", geq[0], 1);
    chk("rst_geq_lvl3", geq[1], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_udf", udf[0], 0);
    chk("rst_dv", dv[0], 0);
    chk("rst_dout", dout[0], 0);
    chk("rst_dv_fwft", dv[2], 0);
    reset_n = 1'b1;
    cyc();
    // fill DEPTH=128 to the brim, then overflow attempt
    wr_n[0] = 1'b0;
    for (int i = 0; i < 128; i++) begin
      din[0] = 8'(i);
      q0.push_back(8'(i));
      cyc();
    end
    chk("a_full", full[0], 1);
    chk("a_count128", cnt[0], 128);
    chk("a_ovf_before", ovf[0], 0);
    din[0] = 8'hAA;
    cyc();
    chk("a_ovf", ovf[0], 1);
    chk("a_count_hold", cnt[0], 128);
    wr_n[0] = 1'b1; rd_n[0] = 1'b0;
    repeat (128) cyc();
    rd_n[0] = 1'b1;
    cyc();
    chk("a_empty", empty[0], 1);
    chk("a_dv_low", dv[0], 0);
    chk("a_udf_none", udf[0], 0);
    fclr[0] = 1'b1;
    cyc();
    fclr[0] = 1'b0;
    chk("a_ovf_cleared", ovf[0], 0);
    // DEPTH=5 wrap with interleaved traffic against a count model
    nw = 0; mc = 0;
    for (int t = 0; t < 200 && (nw < 20 || mc > 0); t++) begin
      w = (nw < 20) && (mc < 5);
      r = (mc > 0) && (t % 3 != 0);
      wr_n[1] = ~w; rd_n[1] = ~r;
      din[1] = 8'(nw * 7 + 3);
      if (w) begin
        q1.push_back(din[1]);
        nw++;
      end
      mc = mc + int'(w) - int'(r);
      cyc();
      chk("b_wrap_count", cnt[1], mc);
    end
    wr_n[1] = 1'b1; rd_n[1] = 1'b1;
    chk("b_wrap_ovf", ovf[1], 0);
    // threshold level=3 on DEPTH=5
    wr_n[1] = 1'b0;
    din[1] = 8'h01; q1.push_back(8'h01); cyc();
    din[1] = 8'h02; q1.push_back(8'h02); cyc();
    chk("b_cnt2", cnt[1], 2);
    chk("b_geq_at2", geq[1], 0);
    din[1] = 8'h03; q1.push_back(8'h03); cyc();
    chk("b_geq_at3", geq[1], 1);
    wr_n[1] = 1'b1; rd_n[1] = 1'b0;
    repeat (3) cyc();
    chk("b_drained", empty[1], 1);
    cyc();
    chk("b_udf_set", udf[1], 1);
    fclr[1] = 1'b1;
    cyc();
    chk("b_udf_set_wins", udf[1], 1);
    rd_n[1] = 1'b1;
    cyc();
    fclr[1] = 1'b0;
    chk("b_udf_cleared", udf[1], 0);
    // FWFT, DEPTH=4
    wr_n[2] = 1'b0; din[2] = 8'h5A; q2.push_back(8'h5A);
    cyc();
    wr_n[2] = 1'b1;
    chk("c_fwft_data", dout[2], 8'h5A);
    chk("c_fwft_valid", dv[2], 1);
    rd_n[2] = 1'b0;
    cyc();
    rd_n[2] = 1'b1;
    chk("c_fwft_empty", empty[2], 1);
    wr_n[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[2] = 8'(8'hC0 + i);
      q2.push_back(din[2]);
      cyc();
    end
    chk("c_full", full[2], 1);
    chk("c_count4", cnt[2], 4);
    din[2] = 8'hC4; q2.push_back(8'hC4); rd_n[2] = 1'b0;
    cyc();
    wr_n[2] = 1'b1;
    chk("c_rw_full_count", cnt[2], 4);
    chk("c_rw_full_ovf", ovf[2], 0);
    repeat (4) cyc();
    rd_n[2] = 1'b1;
    chk("c_drained", empty[2], 1);
    wr_n[2] = 1'b0; rd_n[2] = 1'b0; din[2] = 8'h77; q2.push_back(8'h77);
    cyc();
    wr_n[2] = 1'b1;
    chk("c_rw_empty_count", cnt[2], 1);
    chk("c_rw_empty_udf", udf[2], 1);
    cyc();
    rd_n[2] = 1'b1;
    chk("c_final_empty", empty[2], 1);
    // flush with a pending write at count 7
    wr_n[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din[0] = 8'(8'h40 + i);
      cyc();
    end
    chk("a_cnt7", cnt[0], 7);
    din[0] = 8'hEE; clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0; wr_n[0] = 1'b1;
    chk("a_clr_count", cnt[0], 0);
    chk("a_clr_empty", empty[0], 1);
    chk("a_clr_ovf", ovf[0], 0);
    chk("a_clr_dout", dout[0], 0);
    chk("a_clr_dv", dv[0], 0);
    wr_n[0] = 1'b0; din[0] = 8'h3C; q0.push_back(8'h3C);
    cyc();
    wr_n[0] = 1'b1; rd_n[0] = 1'b0;
    cyc();
    rd_n[0] = 1'b1;
    cyc();
    // asynchronous reset between edges
    wr_n[0] = 1'b0; din[0] = 8'h11; q0.push_back(8'h11); cyc();
    din[0] = 8'h22; cyc();
    wr_n[0] = 1'b1; rd_n[0] = 1'b0; cyc();
    rd_n[0] = 1'b1; cyc();
    chk("a_pre_rst_dout", dout[0], 8'h11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", cnt[0], 0);
    chk("arst_empty", empty[0], 1);
    chk("arst_dout", dout[0], 0);
    chk("arst_geq", geq[0], 1);
    chk("arst_c_udf", udf[2], 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_count", cnt[0], 0);
    chk("sb_a_left", q0.size(), 0);
    chk("sb_b_left", q1.size(), 0);
    chk("sb_c_left", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl_param.md
# uart_fifo_ctrl_param

Parametrised synchronous FIFO controller for the UART transmit and receive paths, generalising the fixed 128x8 UART FIFO. It supports configurable width and depth, a true full count (DEPTH entries), and a programmable fill threshold. It selects between registered-output and first-word-fall-through (FWFT) read modes, adds sticky overflow/underflow error flags and a synchronous flush. Storage is an inferred register array inside the block, so it is portable across device families; it sits between the UART core's rx/tx shifters and the bus register interface.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 128: number of storable entries; any value >= 2, not required to be a power of two.
- CNT_BITS, 8: width of count/level; must satisfy 2^CNT_BITS > DEPTH.
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.

- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active high.
- data_in  in  WIDTH  write data.
- write_n  in  1  write strobe, active low, one word per cycle low.
- read_n  in  1  read strobe, active low, one word per cycle low.
- level  in  CNT_BITS  fill threshold for geq_level.
- flag_clr  in  1  clears sticky overflow/underflow, active high.
- data_out  out  WIDTH  read data.
- data_valid  out  1  FWFT=0: pulse the cycle data_out is updated; FWFT=1: equals ~empty.
- count  out  CNT_BITS  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- geq_level  out  1  count >= level, unsigned compare.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- State: wr_ptr, rd_ptr (0..DEPTH-1, wrap DEPTH-1 -> 0), count, mem[DEPTH], data_out register (FWFT=0), sticky flags.
- Accepted write: ~write_n && (!full || accepted read in the same cycle). Writes mem[wr_ptr] and advances wr_ptr.
- Accepted read: ~read_n && !empty. Advances rd_ptr.
- Count update: +1 on write only; -1 on read only; unchanged on both or neither.
- Write while full with no read: data dropped, pointers unchanged, overflow set.
- Read while empty: ignored, underflow set. A simultaneous write is still accepted, so count goes 0 -> 1.
- Full with simultaneous read and write: both accepted, count stays DEPTH, no overflow.
- FWFT=0: on an accepted read, data_out <= mem[rd_ptr] at that edge and data_valid pulses high for one cycle. Otherwise data_out holds its value and data_valid is 0.
- FWFT=1: data_out = mem[rd_ptr] combinationally; a read strobe consumes the displayed word. data_out is don't-care while empty.
- clr: pointers, count and sticky flags go to 0 and data_valid goes to 0; data_out (FWFT=0) goes to 0. clr has priority over same-cycle reads and writes, which are discarded with no flag set.
- flag_clr: clears overflow/underflow. If a new error occurs in the same cycle, set wins.
- Memory contents are not reset.

## Timing
- Reset values: count=0, empty=1, full=0, geq_level=(level==0), overflow=0, underflow=0, data_valid=0, data_out=0 (FWFT=0).
- Flags are combinational from the count register and update in the cycle after the causing edge.
- Write-to-read latency: a word written at edge N is readable (empty=0) after edge N.
  - FWFT=1: it appears on data_out after edge N.
  - FWFT=0: it appears after the read edge.
- Reset may assert mid-operation; all state clears immediately, without waiting for a clock edge.

## Test plan
- Reset, DEPTH=128, FWFT=0: write 0x00..0x7F on 128 cycles -> full=1, count=128. Write 0xAA -> overflow=1, count stays 128. Read 128 -> data_out 0x00..0x7F in order, each with a data_valid pulse; then empty=1.
- Wrap, DEPTH=5 (non-power-of-two): 3 cycles of write/read interleaved for 20 words -> order preserved across pointer wrap, count never exceeds 5.
- Simultaneous read and write at full (DEPTH=4) -> count stays 4, no overflow, oldest word out. At empty -> count becomes 1, underflow=1, written word is read next.
- FWFT=1: write 0x5A into empty FIFO -> data_out=0x5A and data_valid=1 the next cycle without a read. Read -> empty=1.
- level=3: count 2 -> 3 -> geq_level rises in the cycle after the 3rd write. flag_clr asserted with a same-cycle read-while-empty -> underflow stays 1.
- clr with a write pending at count=7 -> count=0, no overflow. Assert reset_n low between edges -> outputs reach reset values before the next clock.
